// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug read-out path.
// Contents: dump FSM state encoding, frame sync byte, word/byte sizing helpers.
// Ports: none (package).
package mips_dbg_pkg;

  // Dump engine states
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_SEND,
    S_DONE
  } dump_state_e;

  // Frame sync byte sent ahead of the first register word
  localparam logic [7:0] DUMP_HDR = 8'hA5;

  // Architectural register width and the byte count it serializes to
  localparam int DUMP_DATA_W    = 32;
  localparam int BYTES_PER_WORD = DUMP_DATA_W / 8;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Byte counter width; kept at least one bit so single-byte words still elaborate
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one DATA_W word and walks it out MSB-first, one byte per shift.
// Ports: clk/rst; load_i+word_i capture a word and clear the byte count;
//        shift_i advances one byte; byte_nxt_o is the byte that becomes current
//        after a shift; last_o flags that the current byte is the word's final one.
module word_serializer
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W = DUMP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              shift_i,
  output logic [7:0]        byte_nxt_o,
  output logic              last_o
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int CNT_W = cnt_width(BPW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = shift_q << 8;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The top registers tx_data itself, so it needs the byte that will be at
  // the head of the shifter once the current one is accepted.
  generate
    if (DATA_W > 8) begin : g_multi
      assign byte_nxt_o = shift_q[DATA_W-9 -: 8];
    end else begin : g_single
      assign byte_nxt_o = 8'h00;
    end
  endgenerate

  assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: on start, sends HDR_BYTE then every register
// 0..NUM_REGS-1 MSB-first as a valid/ready byte stream toward the UART.
// Ports: clk/rst; start; rd_addr/rd_data spare read port; tx_data/tx_valid/
//        tx_ready byte stream; busy while a dump is in flight; done pulse at end.
module regfile_dump
  import mips_dbg_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter int         ADDR_W   = 5,
  parameter int         DATA_W   = 32,
  parameter logic [7:0] HDR_BYTE = DUMP_HDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;

  logic       accept;
  logic       ser_load;
  logic       ser_shift;
  logic [7:0] ser_byte_nxt;
  logic       ser_last;

  assign accept = tx_valid_q && tx_ready;

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .word_i     (rd_data),
    .shift_i    (ser_shift),
    .byte_nxt_o (ser_byte_nxt),
    .last_o     (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          rd_addr_d  = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
        end
      end

      S_HDR: begin
        if (accept) begin
          state_d    = S_LOAD;
          tx_valid_d = 1'b0;
        end
      end

      // rd_data is sampled here only; later writes to this register are not seen.
      // The first byte is taken straight from the read port so SEND starts with
      // it already registered on tx_data.
      S_LOAD: begin
        ser_load   = 1'b1;
        state_d    = S_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = rd_data[DATA_W-1 -: 8];
      end

      S_SEND: begin
        if (accept) begin
          if (!ser_last) begin
            ser_shift = 1'b1;
            tx_data_d = ser_byte_nxt;
          end else begin
            tx_valid_d = 1'b0;
            // Terminal check before increment so rd_addr never wraps
            if (rd_addr_q == LAST_ADDR) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
              state_d   = S_LOAD;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule
